accum_col_reader: RTL and testbench

//  Drain stage for one accumulator column memory. On start, streams a contiguous block of

---
 rtl/accum_col_reader.sv | 166 ++++++++++++++++
 tb/tb_accum_col_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_col_reader.sv
// accum_col_reader: drains a contiguous row block of one accumulator column onto a
// valid/ready stream through a 2-entry skid FIFO. Define RELU_EN to clamp negative outputs to 0.
module accum_col_reader #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MAX_ROWS_NUM   = 128,
  parameter int unsigned MAX_OUT_COLS   = 128,
  parameter int unsigned SYS_ARR_COLS   = 16,
  localparam int unsigned NUM_ACCUM_ROWS = MAX_ROWS_NUM * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int unsigned AW             = $clog2(NUM_ACCUM_ROWS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [AW-1:0]                base_addr,
  input  logic [AW:0]                  num_rows,
  input  logic                         clear_after,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [AW-1:0]                rd_address,
  input  logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         accum_clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam logic [AW-1:0] LastAddr = AW'(NUM_ACCUM_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [AW:0]             remain_q, remain_d;
  logic                    clear_q, clear_d;
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [2];
  logic [DATA_WIDTH-1:0]   fifo_data_d [2];
  logic [1:0]              fifo_last_q, fifo_last_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    push, pop;
  logic [2:0]              occupancy;
  logic                    credit_ok;
  logic                    issue, issue_last;
  logic [AW-1:0]           issue_addr;
  logic [DATA_WIDTH-1:0]   head;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == LastAddr) ? '0 : a + 1'b1;
  endfunction

  // FIFO bookkeeping; the read returning this cycle lands at the tail.
  always_comb begin
    push        = inflight_q;
    pop         = (count_q != 2'd0) && out_ready;
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = rd_data;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
    end
    // Counting this cycle's pop as a freed slot keeps the stream at one element per cycle.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    credit_ok = occupancy < 3'd2;
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    clear_d         = clear_q;
    issue           = 1'b0;
    issue_last      = 1'b0;
    issue_addr      = '0;
    unique case (state_q)
      StIdle: begin
        // The first read goes out in the start cycle so data is visible two cycles later.
        if (start && rst_n) begin
          clear_d = clear_after;
          if (num_rows == '0) begin
            state_d = StFin;
          end else begin
            issue      = 1'b1;
            issue_addr = base_addr;
            issue_last = (num_rows == (AW+1)'(1));
            addr_d     = addr_inc(base_addr);
            remain_d   = num_rows - (AW+1)'(1);
            state_d    = issue_last ? StDrain : StRead;
          end
        end
      end
      StRead: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_addr = addr_q;
          issue_last = (remain_q == (AW+1)'(1));
          addr_d     = addr_inc(addr_q);
          remain_d   = remain_q - (AW+1)'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (count_d == 2'd0 && !inflight_q) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    inflight_d      = issue;
    inflight_last_d = issue && issue_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      remain_q        <= '0;
      clear_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      clear_q         <= clear_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StFin);
    accum_clear = done && clear_q;
    rd_en       = issue;
    rd_address  = issue ? issue_addr : '0;
    out_valid   = (count_q != 2'd0);
    head        = fifo_data_q[rd_ptr_q];
    out_last    = out_valid && fifo_last_q[rd_ptr_q];
`ifdef RELU_EN
    out_data    = (out_valid && !head[DATA_WIDTH-1]) ? head : '0;
`else
    out_data    = out_valid ? head : '0;
`endif
  end

endmodule

// File: tb/tb_accum_col_reader.sv
// Self-checking bench for accum_col_reader: column memory model plus a scoreboard of
// expected output beats pushed when each block is started.
module tb_accum_col_reader;

  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [AW-1:0]        base_addr = '0;
  logic [AW:0]          num_rows = '0;
  logic                 clear_after = 1'b0;
  logic                 busy, done, rd_en, accum_clear, out_valid, out_last;
  logic [AW-1:0]        rd_address;
  logic signed [DW-1:0] rd_data = '0;
  logic signed [DW-1:0] out_data;
  logic                 out_ready = 1'b0;

  logic [DW-1:0] mem [N];
  logic [DW:0]   exp_q [$];
  int            checks = 0;
  int            errors = 0;

  accum_col_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_rows    (num_rows),
    .clear_after (clear_after),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_address  (rd_address),
    .rd_data     (rd_data),
    .accum_clear (accum_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_address];

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] v);
`ifdef RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic push_expected(input int base, input int num);
    for (int i = 0; i < num; i++)
      exp_q.push_back({(i == num - 1), relu_ref(mem[(base + i) % N])});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, done, rd_en, accum_clear, out_valid, out_last} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {busy, done, rd_en, accum_clear, out_valid, out_last});
    end
    checks++;
    if (rd_address !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%0d data=%0d want 0/0", rd_address, out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // base 0, 4 rows, ready held high: beats on k=2..5, done on k=6, reads on k=0..3.
  task automatic test_basic();
    int rd_cnt = 0;
    int beats = 0;
    int dones = 0;
    logic [DW:0] e;
    mem[0] = 16'sd5; mem[1] = -16'sd3; mem[2] = 16'sd7; mem[3] = 16'sd9;
    exp_q.delete();
    push_expected(0, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = (k == 0); base_addr = '0; num_rows = (AW+1)'(4); clear_after = 1'b0;
      #1;
      if (rd_en) begin
        checks++;
        if (rd_address !== AW'(rd_cnt) || k != rd_cnt) begin
          errors++;
          $display("FAIL basic_rd k=%0d addr=%0d want k=%0d addr=%0d", k, rd_address, rd_cnt, rd_cnt);
        end
        rd_cnt++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({out_last, out_data} !== e || k != beats + 2) begin
          errors++;
          $display("FAIL basic_beat k=%0d got last=%b data=%0d want last=%b data=%0d k=%0d",
                   k, out_last, out_data, e[DW], $signed(e[DW-1:0]), beats + 2);
        end
        beats++;
      end
      if (done) begin
        checks++;
        if (k != 6) begin errors++; $display("FAIL basic_done at k=%0d want k=6", k); end
        dones++;
      end
    end
    start = 1'b0;
    checks++;
    if (rd_cnt != 4 || beats != 4 || dones != 1) begin
      errors++;
      $display("FAIL basic_counts rd=%0d beats=%0d done=%0d want 4/4/1", rd_cnt, beats, dones);
    end
  endtask

  task automatic test_wrap();
    int rd_cnt = 0;
    int beats = 0;
    logic [DW:0] e;
    for (int i = 0; i < 4; i++) mem[(N - 2 + i) % N] = DW'(1000 + 11 * i);
    exp_q.delete();
    push_expected(N - 2, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = (k == 0); base_addr = AW'(N - 2); num_rows = (AW+1)'(4);
      #1;
      if (rd_en) begin
        checks++;
        if (rd_address !== AW'((N - 2 + rd_cnt) % N)) begin
          errors++;
          $display("FAIL wrap_addr got %0d want %0d", rd_address, (N - 2 + rd_cnt) % N);
        end
        rd_cnt++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL wrap_beat got %b/%0d want %b/%0d", out_last, out_data, e[DW],
                   $signed(e[DW-1:0]));
        end
        beats++;
      end
    end
    start = 1'b0;
    checks++;
    if (rd_cnt != 4 || beats != 4) begin
      errors++;
      $display("FAIL wrap_counts rd=%0d beats=%0d want 4/4", rd_cnt, beats);
    end
  endtask

  // out_ready pattern 1,0,0 repeating; occupancy model re-derived from read/pop events.
  task automatic test_backpressure();
    int beats = 0;
    int dones = 0;
    int occ = 0;
    logic re1 = 1'b0, re2 = 1'b0, pop_prev = 1'b0, hold_prev = 1'b0, pop;
    logic [DW-1:0] data_prev = '0;
    logic [DW:0] e;
    for (int i = 0; i < 8; i++) mem[100 + i] = DW'(i * 37 - 100);
    exp_q.delete();
    push_expected(100, 8);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = (k == 0); base_addr = AW'(100); num_rows = (AW+1)'(8);
      out_ready = (k % 3 == 0);
      #1;
      occ = occ + int'(re2) - int'(pop_prev);
      pop = out_valid && out_ready;
      checks++;
      if (out_valid !== (occ != 0) || occ > 2) begin
        errors++;
        $display("FAIL bp_occ k=%0d valid=%b model_occ=%0d", k, out_valid, occ);
      end
      if (rd_en) begin
        checks++;
        if (occ + int'(re1) - int'(pop) >= 2) begin
          errors++;
          $display("FAIL bp_credit k=%0d rd_en=1 want 0 (occ=%0d inflight=%b)", k, occ, re1);
        end
      end
      if (hold_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== data_prev) begin
          errors++;
          $display("FAIL bp_hold k=%0d got %b/%0d want 1/%0d", k, out_valid, out_data,
                   $signed(data_prev));
        end
      end
      if (pop) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL bp_beat got %b/%0d want %b/%0d", out_last, out_data, e[DW],
                   $signed(e[DW-1:0]));
        end
        beats++;
      end
      if (done) dones++;
      hold_prev = out_valid && !out_ready;
      data_prev = out_data;
      re2 = re1; re1 = rd_en; pop_prev = pop;
    end
    start = 1'b0;
    checks++;
    if (beats != 8 || dones != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_counts beats=%0d done=%0d left=%0d want 8/1/0", beats, dones, exp_q.size());
    end
  endtask

  task automatic test_zero_rows();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = (k == 0); base_addr = AW'(5); num_rows = '0;
      #1;
      checks++;
      if ({busy, done, rd_en, out_valid} !== ((k == 1) ? 4'b1100 : 4'b0000)) begin
        errors++;
        $display("FAIL zero_k%0d busy/done/rd_en/valid=%b want %b", k,
                 {busy, done, rd_en, out_valid}, (k == 1) ? 4'b1100 : 4'b0000);
      end
    end
    start = 1'b0;
  endtask

  // Also fires a second start mid-run with different arguments, which must be ignored.
  task automatic test_clear();
    logic [DW:0] e;
    for (int run = 0; run < 2; run++) begin
      int beats = 0;
      int clears = 0;
      mem[7] = 16'sd21; mem[8] = -16'sd40;
      exp_q.delete();
      push_expected(7, 2);
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        start = (k == 0 || k == 2);
        base_addr = (k == 0) ? AW'(7) : AW'(0);
        num_rows = (k == 0) ? (AW+1)'(2) : (AW+1)'(5);
        clear_after = (k == 0) ? (run == 0) : (run != 0);
        #1;
        checks++;
        if (accum_clear !== ((run == 0) && done) || (accum_clear && rd_en)) begin
          errors++;
          $display("FAIL clear_run%0d_k%0d clear=%b want %b", run, k, accum_clear,
                   (run == 0) && done);
        end
        if (accum_clear) clears++;
        if (out_valid && out_ready) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
          checks++;
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL clear_beat got %b/%0d want %b/%0d", out_last, out_data, e[DW],
                     $signed(e[DW-1:0]));
          end
          beats++;
        end
      end
      start = 1'b0;
      checks++;
      if (beats != 2 || clears != ((run == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL clear_counts run%0d beats=%0d clears=%0d want 2/%0d", run, beats, clears,
                 (run == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    int dones = 0;
    logic [DW:0] e;
    for (int i = 0; i < 8; i++) mem[200 + i] = DW'(3 * i - 9);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && beats < 3; k++) begin
      @(negedge clk);
      start = (k == 0); base_addr = AW'(200); num_rows = (AW+1)'(8); clear_after = 1'b1;
      #1;
      if (out_valid && out_ready) beats++;
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, accum_clear, out_valid, out_last} !== 6'b0 ||
        rd_address !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL midreset ctrl=%b addr=%0d data=%0d want all zero",
               {busy, done, rd_en, accum_clear, out_valid, out_last}, rd_address, out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({busy, done, accum_clear, out_valid} !== 4'b0) begin
        errors++;
        $display("FAIL midreset_after k=%0d busy/done/clear/valid=%b want 0000", k,
                 {busy, done, accum_clear, out_valid});
      end
    end
    beats = 0;
    exp_q.delete();
    push_expected(200, 8);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start = (k == 0); base_addr = AW'(200); num_rows = (AW+1)'(8); clear_after = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({out_last, out_data} !== e || k != beats + 2) begin
          errors++;
          $display("FAIL restart_beat k=%0d got %b/%0d want %b/%0d", k, out_last, out_data,
                   e[DW], $signed(e[DW-1:0]));
        end
        beats++;
      end
      if (done) dones++;
    end
    start = 1'b0;
    checks++;
    if (beats != 8 || dones != 1) begin
      errors++;
      $display("FAIL restart_counts beats=%0d done=%0d want 8/1", beats, dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_rows();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
